// File: rtl/fdq_pkg.sv
// Shared constants and entry type for the fetch/decode queue.
package fdq_pkg;

    localparam int unsigned IW_DEF     = 16;
    localparam logic [15:0] NOP_INSTR  = 16'h0800;
    localparam logic [4:0]  HALT_OPCODE = 5'b00000;
    localparam int unsigned OPCODE_MSB = 15;
    localparam int unsigned OPCODE_LSB = 11;

    typedef struct packed {
        logic [IW_DEF-1:0] instr;
        logic [IW_DEF-1:0] pc2;
    } entry_t;

endpackage

// File: rtl/fdq_if.sv
// Fetch/decode handshake bundle; master = pipeline side, slave = queue.
interface fdq_if #(
    parameter int unsigned IW = 16
);
    logic          in_valid;
    logic [IW-1:0] in_instr;
    logic [IW-1:0] in_pc2;
    logic          in_ready;
    logic          out_valid;
    logic [IW-1:0] out_instr;
    logic [IW-1:0] out_pc2;
    logic          out_ready;
    logic          flush;
    logic          halted;

    modport master (
        output in_valid, in_instr, in_pc2, out_ready, flush,
        input  in_ready, out_valid, out_instr, out_pc2, halted
    );

    modport slave (
        input  in_valid, in_instr, in_pc2, out_ready, flush,
        output in_ready, out_valid, out_instr, out_pc2, halted
    );
endinterface

// File: rtl/fdq_storage.sv
// Register array with one write port and asynchronous read; no reset, validity tracked by the owner.
module fdq_storage #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_decode_queue.sv
// IF/ID decoupling FIFO with flush and sticky HALT capture.
// Optional zero-latency empty-queue bypass under `FDQ_BYPASS_EN.
module fetch_decode_queue
    import fdq_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned IW    = 16
) (
    input  logic clk,
    input  logic rst,
    fdq_if.slave bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = 2 * IW;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          halted_q;
    logic [EW-1:0] head;
    logic          empty;
    logic          full;
    logic          enq;
    logic          deq;
    logic          byp;
    logic          wr_en;
    logic          in_is_halt;

    assign empty        = (count == '0);
    assign full         = (count == CW'(DEPTH));
    assign bus.in_ready = !full && !halted_q;
    assign bus.halted   = halted_q;
    assign enq          = bus.in_valid && bus.in_ready && !bus.flush;
    assign deq          = !empty && bus.out_ready && !bus.flush;
    assign in_is_halt   = (bus.in_instr[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);

`ifdef FDQ_BYPASS_EN
    // Empty queue and a ready consumer: hand the word straight through.
    assign byp = empty && bus.in_valid && bus.out_ready && !bus.flush && !halted_q;
`else
    assign byp = 1'b0;
`endif

    assign wr_en = enq && !byp;

    fdq_storage #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (PW)
    ) u_storage (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata ({bus.in_instr, bus.in_pc2}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Pointers, occupancy and the sticky halt flag; flush outranks everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            halted_q <= 1'b0;
        end else if (bus.flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            halted_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (deq)   rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(wr_en) - CW'(deq);
            if (enq && in_is_halt) halted_q <= 1'b1;
        end
    end

    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_instr = IW'(NOP_INSTR);
        bus.out_pc2   = '0;
        if (!empty) begin
            bus.out_valid = 1'b1;
            {bus.out_instr, bus.out_pc2} = head;
        end else if (byp) begin
            bus.out_valid = 1'b1;
            bus.out_instr = bus.in_instr;
            bus.out_pc2   = bus.in_pc2;
        end
    end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue; bypass scenario only when FDQ_BYPASS_EN is defined.
module tb_fetch_decode_queue;
    import fdq_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned IW    = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fdq_if #(.IW(IW)) bus ();

    fetch_decode_queue #(.DEPTH(DEPTH), .IW(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     checks = 0;
    int     errors = 0;
    entry_t sb[$];
    logic   m_halted = 1'b0;

    task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                         input logic rdy, input logic fl);
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.in_pc2    = pc;
        bus.out_ready = rdy;
        bus.flush     = fl;
        #1;
    endtask

    // Advance the reference model with the current inputs, then cross one rising edge.
    task automatic tick();
        logic   exp_rdy;
        logic   byp;
        entry_t e;
        exp_rdy = (sb.size() < DEPTH) && !m_halted;
        if (bus.flush) begin
            sb.delete();
            m_halted = 1'b0;
        end else begin
            byp = 1'b0;
`ifdef FDQ_BYPASS_EN
            byp = (sb.size() == 0) && bus.in_valid && bus.out_ready && !m_halted;
`endif
            if (sb.size() != 0 && bus.out_ready) void'(sb.pop_front());
            if (bus.in_valid && exp_rdy) begin
                e.instr = bus.in_instr;
                e.pc2   = bus.in_pc2;
                if (!byp) sb.push_back(e);
                if (bus.in_instr[15:11] == HALT_OPCODE) m_halted = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_instr !== NOP_INSTR) begin errors++; $display("FAIL reset_instr got %h want %h", bus.out_instr, NOP_INSTR); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.in_ready); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_pc2 !== 16'h0000)
                begin errors++; $display("FAIL idle_state got v=%b r=%b pc2=%h want v=0 r=1 pc2=0000", bus.out_valid, bus.in_ready, bus.out_pc2); end
        end
        // Asynchronous reset mid-cycle with one entry queued.
        drive(1'b1, 16'h1111, 16'h0010, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 16'h1111)
            begin errors++; $display("FAIL pre_reset got v=%b i=%h want v=1 i=1111", bus.out_valid, bus.out_instr); end
        #1 rst = 1'b0;
        #1;
        sb.delete();
        m_halted = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_instr !== NOP_INSTR || bus.in_ready !== 1'b1)
            begin errors++; $display("FAIL async_reset got v=%b i=%h r=%b want v=0 i=0800 r=1", bus.out_valid, bus.out_instr, bus.in_ready); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        drive(1'b1, 16'h4104, 16'h0002, 1'b0, 1'b0);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready0 got %b want 1", bus.in_ready); end
        tick();
        drive(1'b1, 16'h4208, 16'h0004, 1'b0, 1'b0);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready1 got %b want 1", bus.in_ready); end
        tick();
        // Full: an offered word must be refused and leave state unchanged.
        drive(1'b1, 16'h4310, 16'h0006, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", bus.in_ready); end
            checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 16'h4104 || bus.out_pc2 !== 16'h0002)
                begin errors++; $display("FAIL full_head got v=%b i=%h p=%h want v=1 i=4104 p=0002", bus.out_valid, bus.out_instr, bus.out_pc2); end
            tick();
        end
    endtask

    task automatic test_stream();
        int sent = 0;
        int cyc = 0;
        logic [15:0] ins;
        logic [15:0] pc;
        while (sent < 8 && cyc < 40) begin
            ins = {5'b01001, 11'(sent)};
            pc  = 16'(16'h0100 + 2 * sent);
            drive(1'b1, ins, pc, 1'b1, 1'b0);
            checks++; if (bus.in_ready !== ((sb.size() < DEPTH) && !m_halted))
                begin errors++; $display("FAIL stream_ready got %b want %b", bus.in_ready, (sb.size() < DEPTH) && !m_halted); end
            checks++; if (sb.size() == 0 || bus.out_valid !== 1'b1 || bus.out_instr !== sb[0].instr || bus.out_pc2 !== sb[0].pc2)
                begin errors++; $display("FAIL stream_head got v=%b i=%h p=%h want v=1 i=%h p=%h", bus.out_valid, bus.out_instr, bus.out_pc2,
                    sb.size() ? sb[0].instr : 16'hxxxx, sb.size() ? sb[0].pc2 : 16'hxxxx); end
            if (bus.in_ready === 1'b1) sent++;
            tick();
            cyc++;
        end
        checks++; if (sent != 8) begin errors++; $display("FAIL stream_timeout got %0d want 8 words accepted", sent); end
        for (int i = 0; i < 4 && sb.size() != 0; i++) begin
            drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
            checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== sb[0].instr || bus.out_pc2 !== sb[0].pc2)
                begin errors++; $display("FAIL drain_head got v=%b i=%h p=%h want i=%h p=%h", bus.out_valid, bus.out_instr, bus.out_pc2, sb[0].instr, sb[0].pc2); end
            tick();
        end
        drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        checks++; if (bus.out_valid !== 1'b0 || bus.out_instr !== NOP_INSTR || sb.size() != 0)
            begin errors++; $display("FAIL drained got v=%b i=%h want v=0 i=0800", bus.out_valid, bus.out_instr); end
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, 16'h5001, 16'h0200, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h5002, 16'h0202, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h7777, 16'h0204, 1'b1, 1'b1);
        tick();
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        checks++; if (bus.out_valid !== 1'b0 || bus.out_instr !== NOP_INSTR || bus.out_pc2 !== 16'h0000 || bus.in_ready !== 1'b1)
            begin errors++; $display("FAIL flush_state got v=%b i=%h p=%h r=%b want v=0 i=0800 p=0000 r=1", bus.out_valid, bus.out_instr, bus.out_pc2, bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.out_instr === 16'h7777)
            begin errors++; $display("FAIL flush_word got v=%b i=%h want v=0 i=0800", bus.out_valid, bus.out_instr); end
    endtask

    task automatic test_halt();
        drive(1'b1, 16'h4321, 16'h0300, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0000, 16'h0302, 1'b0, 1'b0);
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_early got %b want 0", bus.halted); end
        tick();
        drive(1'b1, 16'h4444, 16'h0304, 1'b1, 1'b0);
        checks++; if (bus.halted !== 1'b1 || bus.in_ready !== 1'b0)
            begin errors++; $display("FAIL halt_set got h=%b r=%b want h=1 r=0", bus.halted, bus.in_ready); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (sb.size() == 0 || bus.out_valid !== 1'b1 || bus.out_instr !== sb[0].instr || bus.out_pc2 !== sb[0].pc2)
                begin errors++; $display("FAIL halt_drain got v=%b i=%h p=%h", bus.out_valid, bus.out_instr, bus.out_pc2); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL halt_ready got %b want 0", bus.in_ready); end
            tick();
        end
        checks++; if (bus.out_valid !== 1'b0 || bus.halted !== 1'b1 || bus.in_ready !== 1'b0)
            begin errors++; $display("FAIL halt_empty got v=%b h=%b r=%b want v=0 h=1 r=0", bus.out_valid, bus.halted, bus.in_ready); end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        tick();
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        checks++; if (bus.halted !== 1'b0 || bus.in_ready !== 1'b1)
            begin errors++; $display("FAIL halt_clear got h=%b r=%b want h=0 r=1", bus.halted, bus.in_ready); end
        tick();
    endtask

`ifdef FDQ_BYPASS_EN
    task automatic test_bypass();
        drive(1'b1, 16'hC0FF, 16'h0400, 1'b1, 1'b0);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 16'hC0FF || bus.out_pc2 !== 16'h0400)
            begin errors++; $display("FAIL bypass_out got v=%b i=%h p=%h want v=1 i=c0ff p=0400", bus.out_valid, bus.out_instr, bus.out_pc2); end
        tick();
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || sb.size() != 0)
            begin errors++; $display("FAIL bypass_count got v=%b r=%b want v=0 r=1", bus.out_valid, bus.in_ready); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_flush();
        test_halt();
`ifdef FDQ_BYPASS_EN
        test_bypass();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Decoupling buffer between the fetch stage and decode; the IF/ID boundary of the pipeline.
- Captures each fetched instruction word with its PC+2 into a small FIFO. Presents them to decode under a valid/ready handshake.
- Converts the instruction-memory stall and decode backpressure into a single fetch stall.
- Discards wrong-path instructions on branch/jump redirect and stops accepting after a HALT is captured.

Parameters:
- DEPTH, 2, number of entries; power of two, minimum 2.
- IW, 16, instruction and PC width in bits.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- in_valid  input  1  fetch has a valid word this cycle (driven as !instrMemStall).
- in_instr  input  IW  fetched instruction word.
- in_pc2  input  IW  PC+2 of that instruction.
- in_ready  output  1  queue accepts a word this cycle; fetch stall = !in_ready.
- out_valid  output  1  head entry valid for decode.
- out_instr  output  IW  head instruction; NOP (16'h0800) when out_valid=0.
- out_pc2  output  IW  head PC+2; 16'h0000 when out_valid=0.
- out_ready  input  1  decode consumes the head this cycle.
- flush  input  1  branch taken or jump redirect; kills all queued and incoming words.
- halted  output  1  sticky: a HALT (opcode 5'b00000) has been enqueued.

Behaviour:
- Reset (rst low, asynchronous):
  - count=0, read/write pointers=0, halted=0.
  - out_valid=0, out_instr=16'h0800, out_pc2=0, in_ready=1.
- Storage and pointers:
  - Circular register array; pointers wrap modulo DEPTH.
  - count is 0..DEPTH, $clog2(DEPTH)+1 bits.
- Enqueue: fires when in_valid && in_ready && !flush. Writes {in_instr, in_pc2} at the write pointer, then advances it.
- Dequeue: fires when out_valid && out_ready && !flush. Advances the read pointer.
- Simultaneous enqueue and dequeue: count unchanged. Legal when full only if in_ready permits; see below.
- in_ready = (count < DEPTH) && !halted. Purely registered-state based; no combinational path from out_ready.
- Full (count==DEPTH): in_ready=0; a same-cycle dequeue does not make in_ready rise until the next cycle.
- Empty (count==0): out_valid=0 and outputs show the NOP; a dequeue request is ignored.
- Default latency: a word enqueued at edge N is visible on the out_* ports after edge N. out_* are driven from the head register.
- Flush has top priority:
  - Next edge: count=0, both pointers=0, halted=0.
  - Any same-cycle in_valid word and any same-cycle dequeue are discarded.
  - out_valid is 0 the cycle after flush.
- HALT capture:
  - When an enqueued word has in_instr[15:11]==5'b00000, halted sets on that edge.
  - While halted=1, in_ready=0; already-queued entries (including the HALT) still drain.
  - halted clears only on flush or reset.
- Reset mid-operation: all entries are dropped immediately (asynchronous). No output glitch beyond the reset values.
- in_valid with in_ready=0: no state change; fetch must hold the word (it stalls the PC).

Optional Feature:
- Macro: FDQ_BYPASS_EN.
- Defined:
  - When count==0, in_valid=1, out_ready=1, no flush and not halted, the incoming word passes combinationally to out_* with out_valid=1 that cycle. It is not written to storage; zero latency.
  - The HALT check still sets halted.
  - This adds a combinational path from in_* to out_*.
- Undefined: minimum latency is one cycle, as above; out_* depend on registered state only.

Decomposition:
- Package fdq_pkg holds:
  - NOP_INSTR = 16'h0800
  - HALT_OPCODE = 5'b00000
  - OPCODE_MSB = 15, OPCODE_LSB = 11
  - a typedef for the entry struct {instr, pc2}.
- One sub-module, fdq_storage: DEPTH x 2·IW register array with write port and asynchronous read. It takes no reset; the validity of its contents is governed by count.
- Pointer/count/halted control stays in the top module.

Test Plan:
- Reset then idle:
  - rst low mid-cycle → out_valid=0, out_instr=16'h0800, in_ready=1 immediately.
  - Remains so with in_valid=0.
- Fill with out_ready=0:
  - Enqueue 16'h4104/pc2 16'h0002, then 16'h4208/16'h0004 → in_ready=0 after the second edge.
  - out_instr=16'h4104, out_pc2=16'h0002.
- Drain and streaming:
  - out_ready=1 with continuous in_valid → one word per cycle, in order, no duplicates or drops.
  - count stays constant.
- Flush with full queue and in_valid=1 → next cycle out_valid=0, out_instr=16'h0800, in_ready=1; the flushed-cycle word never appears.
- HALT:
  - Enqueue 16'h0000 → halted=1 and in_ready=0 next cycle.
  - The HALT still drains to decode; a later flush clears halted.
- Bypass (FDQ_BYPASS_EN):
  - Empty queue, in_valid=1, out_ready=1, in_instr=16'hC0FF → out_instr=16'hC0FF, out_valid=1 the same cycle; count stays 0.
